// File: rtl/inv_round_key_gen_pkg.sv
// -----------------------------------------------------------------------------
// inv_round_key_gen_pkg
// Shared AES-128 constants and helpers for the decrypt-side round-key source.
//   - Byte-lane and key geometry (WORD_SIZE, ARRAY_SIZE, KEY_W)
//   - AES-128 schedule shape (NB, NK, NR)
//   - Round-constant table Rcon[1..10] and the GF(2^8) xtime step
//   - FSM state encoding for the round-key generator
// -----------------------------------------------------------------------------
package inv_round_key_gen_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int ARRAY_SIZE = 16;
  localparam int KEY_W      = WORD_SIZE * ARRAY_SIZE;

  localparam int NB = 4;
  localparam int NK = 4;
  localparam int NR = 10;

  // Rcon[1] .. Rcon[10]; entry i-1 holds the constant used to build round i.
  localparam logic [7:0] RCON_TABLE [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for a given round number; rounds outside 1..NR give zero.
  function automatic logic [7:0] rconLookup(input logic [3:0] round);
    logic [7:0] rc;
    rc = 8'h00;
    for (int i = 1; i <= NR; i++) begin
      if (round == 4'(i)) rc = RCON_TABLE[i-1];
    end
    return rc;
  endfunction

endpackage

// File: rtl/inv_round_key_gen_if.sv
// -----------------------------------------------------------------------------
// inv_round_key_gen_if
// Handshake bundle between a key consumer (master) and the round-key
// generator (slave).
//   enable    : clock enable, all generator state holds while low
//   load      : capture key and start the forward expansion
//   key       : 128-bit cipher key, byte j at [j*8 +: 8]
//   next      : consumer accepts the current round key
//   round_key : current round key, same byte layout as key
//   round_idx : round number of round_key (10 down to 0)
//   valid     : round_key/round_idx are meaningful
//   done      : one-cycle pulse after round 0 has been accepted
// -----------------------------------------------------------------------------
interface inv_round_key_gen_if;
  import inv_round_key_gen_pkg::*;

  logic             enable;
  logic             load;
  logic [KEY_W-1:0] key;
  logic             next;
  logic [KEY_W-1:0] round_key;
  logic [3:0]       round_idx;
  logic             valid;
  logic             done;

  modport master (
    output enable, load, key, next,
    input  round_key, round_idx, valid, done
  );

  modport slave (
    input  enable, load, key, next,
    output round_key, round_idx, valid, done
  );

endinterface

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box.
//   i_byte : input byte
//   o_byte : SubBytes(i_byte)
// The table is stored with entry 0x00 in the most significant byte, so entry b
// lives at bit offset (255-b)*8; ~i_byte is exactly 255-b.
// -----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bitIdx;

  // Bit offset of the selected table entry.
  assign w_bitIdx = {~i_byte, 3'b000};

  // Table read.
  always_comb begin
    o_byte = SBOX_TABLE[w_bitIdx +: 8];
  end

endmodule

// File: rtl/inv_round_key_gen.sv
// -----------------------------------------------------------------------------
// inv_round_key_gen
// Decrypt-side round-key source. Expands the cipher key forward to round 10,
// then walks the schedule backwards, presenting round keys 10, 9, ..., 0 one
// per valid/next handshake. Only the current round key is stored.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : inv_round_key_gen_if slave (enable, load, key, next in;
//         round_key, round_idx, valid, done out)
// -----------------------------------------------------------------------------
module inv_round_key_gen
  import inv_round_key_gen_pkg::*;
(
  input logic                clk,
  input logic                rst,
  inv_round_key_gen_if.slave bus
);

  state_t           r_state;
  logic [KEY_W-1:0] r_roundKey;
  logic [3:0]       r_roundIdx;
  logic [7:0]       r_rcon;
  logic             r_valid;
  logic             r_done;

  logic [31:0]      w_w0, w_w1, w_w2, w_w3;
  logic [31:0]      w_back3;
  logic [31:0]      w_sboxIn;
  logic [31:0]      w_rotWord;
  logic [31:0]      w_subWord;
  logic [7:0]       w_rconSel;
  logic [31:0]      w_mix;
  logic [31:0]      w_fwd0, w_fwd1, w_fwd2, w_fwd3;
  logic [KEY_W-1:0] w_fwdKey;
  logic [KEY_W-1:0] w_bwdKey;

  // Split the held round key into its four schedule words (word c = bytes 4c..4c+3).
  assign w_w0 = r_roundKey[31:0];
  assign w_w1 = r_roundKey[63:32];
  assign w_w2 = r_roundKey[95:64];
  assign w_w3 = r_roundKey[127:96];

  // Going backwards, the previous round's w3 is recovered first; it is the word
  // that fed SubWord when that round was built, so it drives the shared S-boxes.
  assign w_back3   = w_w3 ^ w_w2;
  assign w_sboxIn  = (r_state == ST_READY) ? w_back3 : w_w3;
  assign w_rotWord = {w_sboxIn[7:0], w_sboxIn[31:8]};

  // Four S-box lanes shared by the forward and backward steps.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rotWord[8*g +: 8]),
      .o_byte (w_subWord[8*g +: 8])
    );
  end

  // Forward steps track the constant in a register; backward steps index the
  // table by the round being undone. Rcon sits in the lowest-index byte.
  assign w_rconSel = (r_state == ST_READY) ? rconLookup(r_roundIdx) : r_rcon;
  assign w_mix     = w_subWord ^ {24'h000000, w_rconSel};

  // One forward schedule round.
  assign w_fwd0   = w_w0 ^ w_mix;
  assign w_fwd1   = w_w1 ^ w_fwd0;
  assign w_fwd2   = w_w2 ^ w_fwd1;
  assign w_fwd3   = w_w3 ^ w_fwd2;
  assign w_fwdKey = {w_fwd3, w_fwd2, w_fwd1, w_fwd0};

  // One backward schedule round, undoing the chained XORs from the top word down.
  assign w_bwdKey = {w_back3, w_w2 ^ w_w1, w_w1 ^ w_w0, w_w0 ^ w_mix};

  // Control FSM and round-key register. load restarts from any state and beats
  // next; done is cleared on every enabled cycle so it lasts exactly one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_roundKey <= '0;
      r_roundIdx <= 4'd0;
      r_rcon     <= 8'h01;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else if (bus.enable) begin
      r_done <= 1'b0;
      if (bus.load) begin
        r_state    <= ST_EXPAND;
        r_roundKey <= bus.key;
        r_roundIdx <= 4'd0;
        r_rcon     <= 8'h01;
        r_valid    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_EXPAND: begin
            r_roundKey <= w_fwdKey;
            r_roundIdx <= r_roundIdx + 4'd1;
            r_rcon     <= xtime(r_rcon);
            if (r_roundIdx == 4'(NR - 1)) begin
              r_state <= ST_READY;
              r_valid <= 1'b1;
            end
          end
          ST_READY: begin
            if (bus.next) begin
              if (r_roundIdx != 4'd0) begin
                r_roundKey <= w_bwdKey;
                r_roundIdx <= r_roundIdx - 4'd1;
              end else begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered outputs.
  assign bus.round_key = r_roundKey;
  assign bus.round_idx = r_roundIdx;
  assign bus.valid     = r_valid;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_inv_round_key_gen.sv
// -----------------------------------------------------------------------------
// tb_inv_round_key_gen
// Self-checking bench for inv_round_key_gen. Expected round keys come from a
// byte-level AES-128 key expansion whose S-box is derived from GF(2^8)
// inversion plus the affine map, cross-checked against FIPS-197 vectors.
// -----------------------------------------------------------------------------
module tb_inv_round_key_gen;
  import inv_round_key_gen_pkg::*;

  logic clk;
  logic rst;

  inv_round_key_gen_if bus ();

  inv_round_key_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passCount;
  int checkCount;

  logic [7:0]   sboxModel [256];
  logic [127:0] modelKeys [11];
  logic [127:0] fipsKey;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Convert a key written byte0-first (as printed in FIPS-197) to the bus layout.
  function automatic logic [127:0] fromBytes(input logic [127:0] s);
    logic [127:0] k;
    for (int j = 0; j < 16; j++) k[8*j +: 8] = s[8*(15-j) +: 8];
    return k;
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse, then affine transform.
  task automatic initSbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gfMul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sboxModel[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Standard byte-oriented key expansion into 176 bytes, sliced into 11 round keys.
  task automatic buildModel(input logic [127:0] key);
    logic [7:0] ek [176];
    logic [7:0] t [4];
    logic [7:0] tmp;
    logic [7:0] rc;
    rc = 8'h01;
    for (int j = 0; j < 16; j++) ek[j] = key[8*j +: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = ek[i-4+j];
      if (i % 16 == 0) begin
        tmp  = t[0];
        t[0] = sboxModel[t[1]] ^ rc;
        t[1] = sboxModel[t[2]];
        t[2] = sboxModel[t[3]];
        t[3] = sboxModel[tmp];
        rc   = gfMul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) ek[i+j] = ek[i-16+j] ^ t[j];
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 16; j++) modelKeys[r][8*j +: 8] = ek[16*r + j];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic nx, input logic [127:0] k);
    bus.enable = en;
    bus.load   = ld;
    bus.next   = nx;
    bus.key    = k;
  endtask

  // Bounded wait for valid; the caller checks the cycle count it returns.
  task automatic waitValid(output int cycles);
    cycles = 0;
    while (bus.valid !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    tick();
    tick();
    checkCount++;
    if (bus.round_key !== 128'h0) $display("[TB] FAIL reset_key: got %h want 0", bus.round_key);
    else passCount++;
    checkCount++;
    if (bus.round_idx !== 4'd0) $display("[TB] FAIL reset_idx: got %0d want 0", bus.round_idx);
    else passCount++;
    checkCount++;
    if (bus.valid !== 1'b0 || bus.done !== 1'b0)
      $display("[TB] FAIL reset_flags: got valid=%b done=%b want 0/0", bus.valid, bus.done);
    else passCount++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_expand();
    int cycles;
    $display("[TB] test_fips_expand");
    buildModel(fipsKey);
    applyStimulus(1'b1, 1'b1, 1'b0, fipsKey);
    tick();
    bus.load = 1'b0;
    checkCount++;
    if (bus.valid !== 1'b0 || bus.round_idx !== 4'd0)
      $display("[TB] FAIL load_edge: got valid=%b idx=%0d want 0/0", bus.valid, bus.round_idx);
    else passCount++;
    waitValid(cycles);
    checkCount++;
    if (cycles != 10) $display("[TB] FAIL expand_latency: got %0d want 10", cycles);
    else passCount++;
    checkCount++;
    if (bus.round_idx !== 4'd10) $display("[TB] FAIL expand_idx: got %0d want 10", bus.round_idx);
    else passCount++;
    checkCount++;
    if (bus.round_key !== fromBytes(128'hd014f9a8c9ee2589e13f0cc8b6630ca6))
      $display("[TB] FAIL fips_round10: got %h want %h", bus.round_key,
               fromBytes(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    else passCount++;
    checkCount++;
    if (bus.round_key !== modelKeys[10]) $display("[TB] FAIL model_round10: got %h want %h", bus.round_key, modelKeys[10]);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    bus.next = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      checkCount++;
      if (bus.round_idx !== 4'(r) || bus.round_key !== modelKeys[r] || bus.valid !== 1'b1 || bus.done !== 1'b0)
        $display("[TB] FAIL walk_r%0d: got idx=%0d key=%h v=%b d=%b want idx=%0d key=%h v=1 d=0",
                 r, bus.round_idx, bus.round_key, bus.valid, bus.done, r, modelKeys[r]);
      else passCount++;
      if (r == 1) begin
        checkCount++;
        if (bus.round_key !== fromBytes(128'ha0fafe1788542cb123a339392a6c7605))
          $display("[TB] FAIL fips_round1: got %h want %h", bus.round_key,
                   fromBytes(128'ha0fafe1788542cb123a339392a6c7605));
        else passCount++;
      end
      if (r == 0) begin
        checkCount++;
        if (bus.round_key !== fipsKey) $display("[TB] FAIL round0_is_key: got %h want %h", bus.round_key, fipsKey);
        else passCount++;
      end
      tick();
    end
    checkCount++;
    if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.round_key !== fipsKey)
      $display("[TB] FAIL done_pulse: got d=%b v=%b key=%h want d=1 v=0 key=%h", bus.done, bus.valid, bus.round_key, fipsKey);
    else passCount++;
    bus.next = 1'b0;
    tick();
    checkCount++;
    if (bus.done !== 1'b0 || bus.valid !== 1'b0)
      $display("[TB] FAIL done_single: got d=%b v=%b want 0/0", bus.done, bus.valid);
    else passCount++;
  endtask

  task automatic test_enable_stall();
    int cycles;
    $display("[TB] test_enable_stall");
    applyStimulus(1'b1, 1'b1, 1'b0, fipsKey);
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (bus.round_idx !== 4'd4 || bus.valid !== 1'b0 || bus.round_key !== modelKeys[4])
        $display("[TB] FAIL expand_frozen: got idx=%0d v=%b key=%h want idx=4 v=0 key=%h",
                 bus.round_idx, bus.valid, bus.round_key, modelKeys[4]);
      else passCount++;
    end
    bus.enable = 1'b1;
    waitValid(cycles);
    checkCount++;
    if (cycles + 7 != 13) $display("[TB] FAIL stalled_latency: got %0d want 13", cycles + 7);
    else passCount++;
    bus.next = 1'b1;
    tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (bus.round_idx !== 4'd9 || bus.round_key !== modelKeys[9] || bus.valid !== 1'b1)
        $display("[TB] FAIL ready_frozen: got idx=%0d key=%h v=%b want idx=9 key=%h v=1",
                 bus.round_idx, bus.round_key, bus.valid, modelKeys[9]);
      else passCount++;
    end
    bus.enable = 1'b1;
    for (int r = 9; r >= 0; r--) begin
      checkCount++;
      if (bus.round_idx !== 4'(r) || bus.round_key !== modelKeys[r])
        $display("[TB] FAIL stall_walk_r%0d: got idx=%0d key=%h want key=%h", r, bus.round_idx, bus.round_key, modelKeys[r]);
      else passCount++;
      tick();
    end
    bus.enable = 1'b0;
    bus.next   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (bus.done !== 1'b1 || bus.valid !== 1'b0)
        $display("[TB] FAIL done_held: got d=%b v=%b want d=1 v=0", bus.done, bus.valid);
      else passCount++;
    end
    bus.enable = 1'b1;
    tick();
    checkCount++;
    if (bus.done !== 1'b0) $display("[TB] FAIL done_release: got %b want 0", bus.done);
    else passCount++;
  endtask

  task automatic test_load_in_ready();
    int cycles;
    $display("[TB] test_load_in_ready");
    applyStimulus(1'b1, 1'b1, 1'b0, fipsKey);
    tick();
    bus.load = 1'b0;
    waitValid(cycles);
    bus.next = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.next = 1'b0;
    checkCount++;
    if (bus.round_idx !== 4'd5 || bus.round_key !== modelKeys[5])
      $display("[TB] FAIL at_round5: got idx=%0d key=%h want idx=5 key=%h", bus.round_idx, bus.round_key, modelKeys[5]);
    else passCount++;
    buildModel('0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    tick();
    bus.load = 1'b0;
    checkCount++;
    if (bus.valid !== 1'b0 || bus.round_idx !== 4'd0)
      $display("[TB] FAIL reload_drop: got v=%b idx=%0d want 0/0", bus.valid, bus.round_idx);
    else passCount++;
    waitValid(cycles);
    checkCount++;
    if (cycles != 10) $display("[TB] FAIL reload_latency: got %0d want 10", cycles);
    else passCount++;
    checkCount++;
    if (bus.round_key !== fromBytes(128'hb4ef5bcb3e92e21123e951cf6f8f188e) || bus.round_key !== modelKeys[10])
      $display("[TB] FAIL zero_round10: got %h want %h", bus.round_key, fromBytes(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
    else passCount++;
  endtask

  task automatic test_load_next_together();
    $display("[TB] test_load_next_together");
    applyStimulus(1'b1, 1'b1, 1'b1, fipsKey);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, fipsKey);
    checkCount++;
    if (bus.round_idx !== 4'd0 || bus.valid !== 1'b0 || bus.round_key !== fipsKey || bus.done !== 1'b0)
      $display("[TB] FAIL load_wins: got idx=%0d v=%b d=%b key=%h want idx=0 v=0 d=0 key=%h",
               bus.round_idx, bus.valid, bus.done, bus.round_key, fipsKey);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    int cycles;
    logic [127:0] k;
    $display("[TB] test_reset_mid");
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkCount++;
    if (bus.round_key !== 128'h0 || bus.round_idx !== 4'd0 || bus.valid !== 1'b0 || bus.done !== 1'b0)
      $display("[TB] FAIL mid_reset: got key=%h idx=%0d v=%b d=%b want all 0",
               bus.round_key, bus.round_idx, bus.valid, bus.done);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      bus.next = 1'b1;
      tick();
      bus.next = 1'b0;
      tick();
    end
    checkCount++;
    if (bus.round_key !== 128'h0 || bus.round_idx !== 4'd0 || bus.valid !== 1'b0 || bus.done !== 1'b0)
      $display("[TB] FAIL idle_next_ignored: got key=%h idx=%0d v=%b d=%b want all 0",
               bus.round_key, bus.round_idx, bus.valid, bus.done);
    else passCount++;
    k = {$urandom, $urandom, $urandom, $urandom};
    buildModel(k);
    applyStimulus(1'b1, 1'b1, 1'b0, k);
    tick();
    bus.load = 1'b0;
    waitValid(cycles);
    checkCount++;
    if (cycles != 10 || bus.round_key !== modelKeys[10])
      $display("[TB] FAIL post_reset_expand: got lat=%0d key=%h want lat=10 key=%h", cycles, bus.round_key, modelKeys[10]);
    else passCount++;
  endtask

  task automatic test_random();
    int cycles;
    int expRound;
    int budget;
    logic nx;
    logic [127:0] k;
    $display("[TB] test_random");
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      buildModel(k);
      applyStimulus(1'b1, 1'b1, 1'b0, k);
      tick();
      bus.load = 1'b0;
      waitValid(cycles);
      checkCount++;
      if (cycles != 10) $display("[TB] FAIL rand_latency: got %0d want 10", cycles);
      else passCount++;
      expRound = 10;
      budget   = 0;
      while (budget < 100) begin
        budget++;
        checkCount++;
        if (bus.round_idx !== 4'(expRound) || bus.round_key !== modelKeys[expRound] || bus.valid !== 1'b1)
          $display("[TB] FAIL rand_walk: got idx=%0d key=%h v=%b want idx=%0d key=%h v=1",
                   bus.round_idx, bus.round_key, bus.valid, expRound, modelKeys[expRound]);
        else passCount++;
        nx = 1'($urandom_range(0, 1));
        bus.next = nx;
        tick();
        if (nx) begin
          if (expRound == 0) break;
          expRound--;
        end
      end
      bus.next = 1'b0;
      checkCount++;
      if (bus.done !== 1'b1 || bus.valid !== 1'b0 || budget >= 100)
        $display("[TB] FAIL rand_done: got d=%b v=%b steps=%0d want d=1 v=0", bus.done, bus.valid, budget);
      else passCount++;
      tick();
    end
  endtask

  // Test sequence.
  initial begin
    passCount  = 0;
    checkCount = 0;
    rst        = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    initSbox();
    fipsKey = fromBytes(128'h2b7e151628aed2a6abf7158809cf4f3c);
    test_reset();
    test_fips_expand();
    test_back_to_back();
    buildModel(fipsKey);
    test_enable_stall();
    test_load_in_ready();
    test_load_next_together();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
